// File: rtl/riscv_defs_pkg.sv
// Shared RV32 definitions: XLEN, NOP encoding
// and fetch-stage state encoding.
package riscv_defs;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } fetch_state_e;
endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, one-outstanding imem request,
// redirect/squash handling and decode hand-off.
module instruction_fetch_unit
  import riscv_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic            misalign_fault
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic [XLEN-1:0] ipc4_q, ipc4_d;
  logic            req_valid_q, req_valid_d;
  logic            ivalid_q, ivalid_d;
  logic            squash_q, squash_d;
  logic            fault_q, fault_d;
  logic            fpend_q, fpend_d;

  logic            redir_ok;
  logic            redir_bad;
  logic            kill;
  logic [XLEN-1:0] tgt;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    req_valid_d = req_valid_q;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    ipc4_d      = ipc4_q;
    ivalid_d    = ivalid_q;
    squash_d    = squash_q;
    fault_d     = fault_q;
    fpend_d     = fpend_q;

    redir_ok  = redirect_valid
             && (redirect_pc[1:0] == 2'b00);
    redir_bad = redirect_valid
             && (redirect_pc[1:0] != 2'b00);
    // a pending fault overrides later redirects
    kill      = fpend_q || redir_bad;
    tgt       = redir_ok ? redirect_pc : pc_q;

    if (redir_bad) fault_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (kill) begin
          state_d = S_FAULT;
        end else begin
          state_d     = S_REQ;
          req_valid_d = 1'b1;
          req_addr_d  = tgt;
          pc_d        = tgt;
        end
      end
      S_REQ: begin
        if (kill) begin
          fpend_d = 1'b1;
        end else if (redir_ok) begin
          pc_d     = redirect_pc;
          squash_d = 1'b1;
        end
        if (imem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (kill) fpend_d = 1'b1;
        if (imem_rsp_valid) begin
          squash_d = 1'b0;
          if (kill) begin
            fpend_d = 1'b0;
            state_d = S_FAULT;
          end else if (squash_q || redir_ok) begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            req_addr_d  = tgt;
            pc_d        = tgt;
          end else begin
            instr_d  = imem_rsp_data;
            ipc_d    = pc_q;
            ipc4_d   = pc_q + 32'd4;
            ivalid_d = 1'b1;
            state_d  = S_HOLD;
          end
        end else if (redir_ok && !kill) begin
          pc_d     = redirect_pc;
          squash_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (kill) begin
          ivalid_d = 1'b0;
          state_d  = S_FAULT;
        end else if (redir_ok || if_ready) begin
          ivalid_d    = 1'b0;
          pc_d        = redir_ok ? redirect_pc
                                 : pc_q + 32'd4;
          req_addr_d  = pc_d;
          req_valid_d = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_FAULT: begin
        req_valid_d = 1'b0;
        ivalid_d    = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      instr_q     <= NOP_INSTR;
      ipc_q       <= RESET_PC;
      ipc4_q      <= RESET_PC + 32'd4;
      ivalid_q    <= 1'b0;
      squash_q    <= 1'b0;
      fault_q     <= 1'b0;
      fpend_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      req_valid_q <= req_valid_d;
      instr_q     <= instr_d;
      ipc_q       <= ipc_d;
      ipc4_q      <= ipc4_d;
      ivalid_q    <= ivalid_d;
      squash_q    <= squash_d;
      fault_q     <= fault_d;
      fpend_q     <= fpend_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign if_valid       = ivalid_q;
  assign if_instr       = instr_q;
  assign if_pc          = ipc_q;
  assign if_pc_plus4    = ipc4_q;
  assign misalign_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with
// a latency-programmable instruction memory model.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        misalign_fault;

  int total = 0;
  int bad = 0;

  instruction_fetch_unit #(.RESET_PC(32'h100)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc_plus4),
    .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0bad_f00d;
  endfunction

  // memory: latency mem_lat cycles from acceptance
  int          mem_lat = 1;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0;
  logic [31:0] req_log[$];
  bit          acc;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_data;

  always @(posedge clk) begin
    acc = imem_req_valid && imem_req_ready;
    if (acc) begin
      req_log.push_back(imem_req_addr);
      pend_data = ovr_en ? ovr_data : word(imem_req_addr);
    end
    #1;
    imem_rsp_valid = 1'b0;
    if (acc) begin
      pend = 1'b1;
      cnt  = mem_lat;
    end
    if (pend) begin
      if (cnt <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend_data;
        pend = 1'b0;
      end else begin
        cnt--;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (if_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    repeat (3) tick();
    total++;
    if (imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_req_valid got=%b want=0", imem_req_valid);
    end
    total++;
    if (imem_req_addr !== 32'h100) begin
      bad++;
      $display("FAIL rst_req_addr got=%h want=100", imem_req_addr);
    end
    total++;
    if (if_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_if_valid got=%b want=0", if_valid);
    end
    total++;
    if (if_instr !== 32'h13) begin
      bad++;
      $display("FAIL rst_if_instr got=%h want=13", if_instr);
    end
    total++;
    if (if_pc !== 32'h100 || misalign_fault !== 1'b0) begin
      bad++;
      $display("FAIL rst_pc_fault got=%h/%b want=100/0", if_pc, misalign_fault);
    end
  endtask

  task automatic test_stream;
    bit ok;
    logic [31:0] e;
    req_log.delete();
    reset = 1'b0;
    tick();
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      bad++;
      $display("FAIL start_req got=%b/%h want=1/100", imem_req_valid, imem_req_addr);
    end
    tick();
    total++;
    if (if_valid !== 1'b0) begin
      bad++;
      $display("FAIL early_valid got=%b want=0", if_valid);
    end
    tick();
    total++;
    if (if_valid !== 1'b1) begin
      bad++;
      $display("FAIL first_valid_latency got=%b want=1", if_valid);
    end
    for (int k = 0; k < 3; k++) begin
      e = 32'h100 + 32'(4 * k);
      wait_valid(ok);
      total++;
      if (!ok || if_pc !== e || if_instr !== word(e)) begin
        bad++;
        $display("FAIL stream_%0d got=%h/%h want=%h/%h", k, if_pc, if_instr, e, word(e));
      end
      total++;
      if (if_pc_plus4 !== e + 32'd4) begin
        bad++;
        $display("FAIL stream_pc4_%0d got=%h want=%h", k, if_pc_plus4, e + 32'd4);
      end
      total++;
      if (req_log.size() <= k || req_log[k] !== e) begin
        bad++;
        $display("FAIL stream_addr_%0d got=%0d entries want=%h", k, req_log.size(), e);
      end
      tick();
    end
  endtask

  task automatic test_hold_stall;
    bit ok;
    bit moved = 1'b0;
    if_ready = 1'b0;
    wait_valid(ok);
    total++;
    if (!ok || if_pc !== 32'h10C) begin
      bad++;
      $display("FAIL stall_setup got=%h want=10c", if_pc);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (if_valid !== 1'b1 || if_pc !== 32'h10C
          || if_instr !== word(32'h10C) || imem_req_valid !== 1'b0)
        moved = 1'b1;
    end
    total++;
    if (moved) begin
      bad++;
      $display("FAIL stall_stable got=%b/%h/%b want=1/10c/0", if_valid, if_pc, imem_req_valid);
    end
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    total++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h110) begin
      bad++;
      $display("FAIL stall_release got=%b/%b/%h want=0/1/110", if_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_wait;
    bit ok;
    wait_valid(ok);
    total++;
    if (!ok || if_pc !== 32'h110) begin
      bad++;
      $display("FAIL rw_setup got=%h want=110", if_pc);
    end
    mem_lat = 3;
    ovr_en = 1'b1;
    ovr_data = 32'hDEAD_BEEF;
    req_log.delete();
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    tick();
    ovr_en = 1'b0;
    mem_lat = 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL rw_quiet got=%b/%b want=0/0", if_valid, imem_req_valid);
    end
    wait_valid(ok);
    total++;
    if (!ok || if_pc !== 32'h200 || if_instr !== word(32'h200)) begin
      bad++;
      $display("FAIL rw_target got=%h/%h want=200/%h", if_pc, if_instr, word(32'h200));
    end
    total++;
    if (req_log.size() != 2 || req_log[1] !== 32'h200) begin
      bad++;
      $display("FAIL rw_req_seq got=%0d entries want=2 ending 200", req_log.size());
    end
  endtask

  task automatic test_redirect_rsp;
    bit ok;
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300 || if_valid !== 1'b0) begin
      bad++;
      $display("FAIL rr_req got=%b/%h/%b want=1/300/0", imem_req_valid, imem_req_addr, if_valid);
    end
    wait_valid(ok);
    total++;
    if (!ok || if_pc !== 32'h300 || if_instr !== word(32'h300)) begin
      bad++;
      $display("FAIL rr_target got=%h/%h want=300/%h", if_pc, if_instr, word(32'h300));
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    mem_lat = 4;
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    tick();
    mem_lat = 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    tick();
    redirect_pc = 32'h500;
    tick();
    redirect_valid = 1'b0;
    wait_valid(ok);
    total++;
    if (!ok || if_pc !== 32'h500 || if_instr !== word(32'h500)) begin
      bad++;
      $display("FAIL b2b_last_wins got=%h/%h want=500/%h", if_pc, if_instr, word(32'h500));
    end
  endtask

  task automatic test_ready_low;
    bit ok;
    imem_req_ready = 1'b0;
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h504) begin
        bad++;
        $display("FAIL rl_stable_%0d got=%b/%h want=1/504", i, imem_req_valid, imem_req_addr);
      end
    end
    imem_req_ready = 1'b1;
    wait_valid(ok);
    total++;
    if (!ok || if_pc !== 32'h504) begin
      bad++;
      $display("FAIL rl_fetch got=%h want=504", if_pc);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (if_valid !== 1'b0 || imem_req_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_hold_redir got=%b/%h want=0/fffffffc", if_valid, imem_req_addr);
    end
    wait_valid(ok);
    total++;
    if (!ok || if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0) begin
      bad++;
      $display("FAIL wrap_pc4 got=%h/%h want=fffffffc/0", if_pc, if_pc_plus4);
    end
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      bad++;
      $display("FAIL wrap_next got=%b/%h want=1/0", imem_req_valid, imem_req_addr);
    end
    wait_valid(ok);
    total++;
    if (!ok || if_pc !== 32'h0 || if_instr !== word(32'h0)) begin
      bad++;
      $display("FAIL wrap_fetch got=%h want=0", if_pc);
    end
  endtask

  task automatic test_misalign;
    bit act = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h202;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (misalign_fault !== 1'b1 || if_valid !== 1'b0) begin
      bad++;
      $display("FAIL ma_fault got=%b/%b want=1/0", misalign_fault, if_valid);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req_valid || if_valid || !misalign_fault) act = 1'b1;
    end
    total++;
    if (act) begin
      bad++;
      $display("FAIL ma_sticky got=%b/%b want=0/0 fault=%b", imem_req_valid, if_valid, misalign_fault);
    end
    reset = 1'b1;
    tick();
    total++;
    if (misalign_fault !== 1'b0 || if_pc !== 32'h100 || if_instr !== 32'h13) begin
      bad++;
      $display("FAIL ma_reset got=%b/%h/%h want=0/100/13", misalign_fault, if_pc, if_instr);
    end
    reset = 1'b0;
    mem_lat = 3;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h206;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (misalign_fault !== 1'b1 || imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL ma_wait_fault got=%b/%b want=1/0", misalign_fault, imem_req_valid);
    end
    act = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req_valid || if_valid) act = 1'b1;
    end
    total++;
    if (act) begin
      bad++;
      $display("FAIL ma_drain got=%b/%b want=0/0", imem_req_valid, if_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_rsp();
    test_back_to_back();
    test_ready_low();
    test_wrap();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
